// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO family: read-mode constants and a
// constant-evaluable ceiling log2 used to size pointers and counts.
package fifo_pkg;

   localparam int unsigned FIFO_STD  = 0;
   localparam int unsigned FIFO_FWFT = 1;

   function automatic int unsigned clog2(input int unsigned value);
      int unsigned result;
      result = 0;
      while ((32'd1 << result) < value) begin
         result = result + 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage array: synchronous write port and
// asynchronous (combinational) read port.
module fifo_ram
   import fifo_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 16,
   localparam int unsigned AW   = clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/param_fifo.sv
// Parametrised single-clock FIFO with standard or first-word-fall-through
// read mode, registered threshold flags, sticky error flags and a flush.
module param_fifo
   import fifo_pkg::*;
#(
   parameter int unsigned WIDTH    = 32,
   parameter int unsigned DEPTH    = 16,
   parameter int unsigned FWFT     = FIFO_STD,
   parameter int unsigned AF_LEVEL = DEPTH - 2,
   parameter int unsigned AE_LEVEL = 2,
   localparam int unsigned AW      = clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             clr,
   input  logic             we,
   input  logic [WIDTH-1:0] din,
   input  logic             re,
   output logic [WIDTH-1:0] dout,
   output logic             valid,
   output logic             empty,
   output logic             full,
   output logic             almost_empty,
   output logic             almost_full,
   output logic [AW:0]      count,
   output logic             overflow,
   output logic             underflow
);

   localparam logic [AW:0] AE_CNT  = (AW + 1)'(AE_LEVEL);
   localparam logic [AW:0] AF_CNT  = (AW + 1)'(AF_LEVEL);
   localparam logic [AW:0] ONE     = {{AW{1'b0}}, 1'b1};
   localparam logic        AF_INIT = (AF_LEVEL == 0);

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("param_fifo: DEPTH must be a power of two and at least 2");
   end
   if (!(AE_LEVEL < AF_LEVEL && AF_LEVEL <= DEPTH)) begin : g_bad_levels
      $error("param_fifo: thresholds must satisfy AE_LEVEL < AF_LEVEL <= DEPTH");
   end
   if (FWFT > FIFO_FWFT) begin : g_bad_mode
      $error("param_fifo: FWFT must be FIFO_STD or FIFO_FWFT");
   end

   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic [AW:0]      wr_ptr_nxt;
   logic [AW:0]      rd_ptr_nxt;
   logic [AW:0]      count_nxt;
   logic             rd_ok;
   logic             wr_ok;
   logic [WIDTH-1:0] rd_data;
   logic [WIDTH-1:0] dout_q;
   logic             valid_q;

   always_comb begin
      rd_ok      = re && !empty;
      wr_ok      = we && (!full || rd_ok);
      wr_ptr_nxt = wr_ptr + (wr_ok ? ONE : '0);
      rd_ptr_nxt = rd_ptr + (rd_ok ? ONE : '0);
      count_nxt  = count;
      if (wr_ok && !rd_ok) begin
         count_nxt = count + ONE;
      end else if (rd_ok && !wr_ok) begin
         count_nxt = count - ONE;
      end
   end

   // Flags are computed from next-state pointers/count so they are registered yet current.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         empty        <= 1'b1;
         full         <= 1'b0;
         almost_empty <= 1'b1;
         almost_full  <= AF_INIT;
         overflow     <= 1'b0;
         underflow    <= 1'b0;
         valid_q      <= 1'b0;
         dout_q       <= '0;
      end else if (clr) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         empty        <= 1'b1;
         full         <= 1'b0;
         almost_empty <= 1'b1;
         almost_full  <= AF_INIT;
         overflow     <= 1'b0;
         underflow    <= 1'b0;
         valid_q      <= 1'b0;
      end else begin
         wr_ptr       <= wr_ptr_nxt;
         rd_ptr       <= rd_ptr_nxt;
         count        <= count_nxt;
         empty        <= (wr_ptr_nxt == rd_ptr_nxt);
         full         <= (wr_ptr_nxt == {~rd_ptr_nxt[AW], rd_ptr_nxt[AW-1:0]});
         almost_empty <= (count_nxt <= AE_CNT);
         almost_full  <= (count_nxt >= AF_CNT);
         overflow     <= overflow | (we && !wr_ok);
         underflow    <= underflow | (re && !rd_ok);
         valid_q      <= rd_ok;
         if (rd_ok) begin
            dout_q <= rd_data;
         end
      end
   end

   fifo_ram #(
      .WIDTH(WIDTH),
      .DEPTH(DEPTH)
   ) u_ram (
      .clk  (clk),
      .we   (wr_ok && !clr),
      .waddr(wr_ptr[AW-1:0]),
      .wdata(din),
      .raddr(rd_ptr[AW-1:0]),
      .rdata(rd_data)
   );

   if (FWFT == FIFO_FWFT) begin : g_fwft
      // Storage is not reset, so the head word is masked to zero while empty.
      assign dout  = empty ? '0 : rd_data;
      assign valid = !empty;
   end else begin : g_std
      assign dout  = dout_q;
      assign valid = valid_q;
   end

endmodule

// File: tb/tb_param_fifo.sv
// Scoreboard bench for param_fifo: a standard-mode 32x16 instance and a
// first-word-fall-through 8x4 instance driven with directed vectors.
module tb_param_fifo;
   import fifo_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset_n;
   logic        a_clr, a_we, a_re;
   logic [31:0] a_din, a_dout;
   logic        a_valid, a_empty, a_full, a_ae, a_af, a_ovf, a_unf;
   logic [4:0]  a_count;

   logic        b_clr, b_we, b_re;
   logic [7:0]  b_din, b_dout;
   logic        b_valid, b_empty, b_full, b_ae, b_af, b_ovf, b_unf;
   logic [2:0]  b_count;

   param_fifo #(
      .WIDTH(32), .DEPTH(16), .FWFT(FIFO_STD), .AF_LEVEL(14), .AE_LEVEL(2)
   ) dut_a (
      .clk(clk), .reset_n(reset_n), .clr(a_clr), .we(a_we), .din(a_din), .re(a_re),
      .dout(a_dout), .valid(a_valid), .empty(a_empty), .full(a_full),
      .almost_empty(a_ae), .almost_full(a_af), .count(a_count),
      .overflow(a_ovf), .underflow(a_unf)
   );

   param_fifo #(
      .WIDTH(8), .DEPTH(4), .FWFT(FIFO_FWFT), .AF_LEVEL(3), .AE_LEVEL(1)
   ) dut_b (
      .clk(clk), .reset_n(reset_n), .clr(b_clr), .we(b_we), .din(b_din), .re(b_re),
      .dout(b_dout), .valid(b_valid), .empty(b_empty), .full(b_full),
      .almost_empty(b_ae), .almost_full(b_af), .count(b_count),
      .overflow(b_ovf), .underflow(b_unf)
   );

   typedef struct {
      logic [31:0] data;
      int unsigned due;
   } exp_t;

   exp_t        aq[$];
   logic [7:0]  bq[$];
   int          tests = 0;
   int          fails = 0;
   int unsigned cyc   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_a(input logic [31:0] d);
      exp_t e;
      e.data = d;
      e.due  = cyc + 1;
      aq.push_back(e);
   endtask

   // Standard-mode monitor: every valid must match the oldest expected read, on time.
   always @(negedge clk) begin : mon_a
      exp_t e;
      if (reset_n) begin
         if (a_valid) begin
            tests++;
            if (aq.size() == 0) begin
               fails++;
               $display("FAIL a_unexpected_valid: got dout %0h with valid, required no valid", a_dout);
            end else begin
               e = aq.pop_front();
               if (a_dout !== e.data || cyc != e.due) begin
                  fails++;
                  $display("FAIL a_read: got %0h at cycle %0d, required %0h at cycle %0d",
                           a_dout, cyc, e.data, e.due);
               end
            end
         end else if (aq.size() != 0 && aq[0].due <= cyc) begin
            tests++;
            fails++;
            e = aq.pop_front();
            $display("FAIL a_missing_valid: got valid 0 at cycle %0d, required %0h", cyc, e.data);
         end
      end
   end

   // FWFT monitor: the head word presented while re is high is the one popped.
   always @(negedge clk) begin : mon_b
      logic [7:0] e;
      if (reset_n && b_re && b_valid) begin
         tests++;
         if (bq.size() == 0) begin
            fails++;
            $display("FAIL b_unexpected_pop: got %0h, required nothing to pop", b_dout);
         end else begin
            e = bq.pop_front();
            if (b_dout !== e) begin
               fails++;
               $display("FAIL b_pop: got %0h, required %0h", b_dout, e);
            end
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "timeout");
   end

   initial begin : stim
      logic [31:0] exp_d;
      reset_n = 1'b0;
      a_clr = 1'b0; a_we = 1'b0; a_re = 1'b0; a_din = '0;
      b_clr = 1'b0; b_we = 1'b0; b_re = 1'b0; b_din = '0;
      #12;
      chk("rst_count", a_count, 0);
      chk("rst_empty", a_empty, 1);
      chk("rst_full", a_full, 0);
      chk("rst_ae", a_ae, 1);
      chk("rst_af", a_af, 0);
      chk("rst_ovf", a_ovf, 0);
      chk("rst_unf", a_unf, 0);
      chk("rst_valid", a_valid, 0);
      chk("rst_dout", a_dout, 0);
      chk("rst_b_empty", b_empty, 1);
      tick();
      reset_n = 1'b1;
      tick();

      // Fill 0..15
      for (int i = 0; i < 16; i++) begin
         a_we = 1'b1;
         a_din = i;
         tick();
         chk("fill_count", a_count, i + 1);
         chk("fill_af", a_af, (i + 1) >= 14);
         chk("fill_ae", a_ae, (i + 1) <= 2);
      end
      a_we = 1'b0;
      chk("fill_full", a_full, 1);
      chk("fill_empty", a_empty, 0);

      // Full with simultaneous write and read
      a_we = 1'b1; a_din = 32'hAA; a_re = 1'b1;
      push_a(32'd0);
      tick();
      a_we = 1'b0; a_re = 1'b0;
      chk("wr_rd_full_count", a_count, 16);
      chk("wr_rd_full_full", a_full, 1);
      chk("wr_rd_full_ovf", a_ovf, 0);

      a_we = 1'b1; a_din = 32'hBB;
      tick();
      a_we = 1'b0;
      chk("ovf_set", a_ovf, 1);
      chk("ovf_count", a_count, 16);

      // Drain: 1..15 then 0xAA
      for (int i = 0; i < 16; i++) begin
         exp_d = (i < 15) ? 32'(i + 1) : 32'hAA;
         a_re = 1'b1;
         push_a(exp_d);
         tick();
         chk("drain_count", a_count, 15 - i);
         chk("drain_ae", a_ae, (15 - i) <= 2);
         chk("drain_af", a_af, (15 - i) >= 14);
      end
      a_re = 1'b0;
      chk("drain_empty", a_empty, 1);
      chk("drain_unf", a_unf, 0);
      tick();

      // Empty with simultaneous write and read: read is dropped
      a_we = 1'b1; a_din = 32'h77; a_re = 1'b1;
      tick();
      a_we = 1'b0; a_re = 1'b0;
      chk("empty_wr_rd_unf", a_unf, 1);
      chk("empty_wr_rd_count", a_count, 1);
      chk("empty_wr_rd_dout", a_dout, 32'hAA);
      chk("empty_wr_rd_valid", a_valid, 0);

      for (int i = 0; i < 8; i++) begin
         a_we = 1'b1;
         a_din = 32'h100 + i;
         tick();
      end
      a_we = 1'b0;
      chk("pre_clr_count", a_count, 9);
      chk("pre_clr_ovf", a_ovf, 1);

      // Flush wins over a same-cycle write
      a_clr = 1'b1; a_we = 1'b1; a_din = 32'hDEAD;
      tick();
      a_clr = 1'b0; a_we = 1'b0;
      chk("clr_count", a_count, 0);
      chk("clr_empty", a_empty, 1);
      chk("clr_ovf", a_ovf, 0);
      chk("clr_unf", a_unf, 0);
      chk("clr_dout", a_dout, 32'hAA);
      chk("clr_valid", a_valid, 0);

      // FWFT instance
      b_we = 1'b1; b_din = 8'h05;
      tick();
      b_we = 1'b0;
      chk("fwft_dout", b_dout, 8'h05);
      chk("fwft_empty", b_empty, 0);
      chk("fwft_count", b_count, 1);
      tick();
      chk("fwft_hold", b_dout, 8'h05);
      b_re = 1'b1;
      bq.push_back(8'h05);
      tick();
      b_re = 1'b0;
      chk("fwft_pop_empty", b_empty, 1);

      for (int i = 1; i <= 3; i++) begin
         b_we = 1'b1;
         b_din = 8'(i * 8'h11);
         tick();
      end
      b_we = 1'b0;
      chk("fwft_af", b_af, 1);
      chk("fwft_count3", b_count, 3);
      chk("fwft_head", b_dout, 8'h11);

      for (int i = 0; i < 5; i++) begin
         b_re = 1'b1;
         bq.push_back(8'((i + 1) * 8'h11));
         b_we = (i < 2);
         b_din = 8'((i + 4) * 8'h11);
         tick();
         chk("fwft_stream_count", b_count, (i < 2) ? 3 : 4 - i);
      end
      b_re = 1'b0; b_we = 1'b0;
      chk("fwft_stream_empty", b_empty, 1);

      // Asynchronous reset mid-stream
      for (int i = 0; i < 3; i++) begin
         a_we = 1'b1; a_din = 32'h200 + i;
         b_we = 1'b1; b_din = 8'h60 + 8'(i);
         tick();
      end
      a_re = 1'b1; b_we = 1'b0;
      #2;
      reset_n = 1'b0;
      #1;
      chk("arst_count", a_count, 0);
      chk("arst_empty", a_empty, 1);
      chk("arst_full", a_full, 0);
      chk("arst_ae", a_ae, 1);
      chk("arst_af", a_af, 0);
      chk("arst_ovf", a_ovf, 0);
      chk("arst_unf", a_unf, 0);
      chk("arst_valid", a_valid, 0);
      chk("arst_dout", a_dout, 0);
      chk("arst_b_count", b_count, 0);
      chk("arst_b_dout", b_dout, 0);
      a_we = 1'b0; a_re = 1'b0;
      tick();
      reset_n = 1'b1;
      tick();
      chk("post_rst_empty", a_empty, 1);
      chk("a_queue_drained", aq.size(), 0);
      chk("b_queue_drained", bq.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
